// File: rtl/mem_display_reader.sv
// Fetches a run of data-memory words and shows each word's low 16 bits on a 4-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module mem_display_reader #(
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  input  logic [31:0]      mem_rdata,
  output logic [7:0]       seg,
  output logic [3:0]       an,
  output logic [7:0]       led,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SHOW, S_DONE} state_t;

  state_t            state_q;
  logic [31:0]       base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  idx_q;
  logic [HOLD_W-1:0] hold_q;
  logic [15:0]       word_q;
  logic [7:0]        led_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_read_q;
  logic [31:0]       mem_addr_q;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;

  logic [31:0]      base_aligned;
  logic [CNT_W-1:0] idx_inc;
  logic [31:0]      next_addr;
  logic             hold_done;
  logic             unused_bits;

  assign base_aligned = {base_addr[31:2], 2'b00};
  assign idx_inc      = idx_q + CNT_W'(1);
  assign next_addr    = base_q + (32'(idx_inc) << 2);
  assign hold_done    = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  // Only the low half of each word is ever displayed.
  assign unused_bits  = ^{mem_rdata[31:16], base_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      word_q     <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !stop) begin
            base_q  <= base_aligned;
            count_q <= word_count;
            idx_q   <= '0;
            if (word_count == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_READ;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              mem_read_q <= 1'b1;
              mem_addr_q <= base_aligned;
            end
          end
        end
        S_READ: begin
          mem_read_q <= 1'b0;
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            word_q  <= mem_rdata[15:0];
            led_q   <= 8'(idx_q);
            hold_q  <= '0;
            state_q <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (hold_done) begin
            if (idx_inc == count_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q      <= idx_inc;
              state_q    <= S_READ;
              mem_read_q <= 1'b1;
              mem_addr_q <= next_addr;
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [3:0] nibble;
  logic       blank;

  always_comb begin
    nibble = '0;
    case (digit_q)
      2'd0: nibble = word_q[3:0];
      2'd1: nibble = word_q[7:4];
      2'd2: nibble = word_q[11:8];
      2'd3: nibble = word_q[15:12];
      default: nibble = '0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (digit_q)
      2'd1: blank = (word_q[15:4] == '0);
      2'd2: blank = (word_q[15:8] == '0);
      2'd3: blank = (word_q[15:12] == '0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    scan_d  = scan_q + SCAN_W'(1);
    digit_d = digit_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end
    an_d  = ~(4'b0001 << digit_q);
    seg_d = 8'hFF;
    if (!blank) begin
      case (nibble)
        4'h0: seg_d = 8'hC0;
        4'h1: seg_d = 8'hF9;
        4'h2: seg_d = 8'hA4;
        4'h3: seg_d = 8'hB0;
        4'h4: seg_d = 8'h99;
        4'h5: seg_d = 8'h92;
        4'h6: seg_d = 8'h82;
        4'h7: seg_d = 8'hF8;
        4'h8: seg_d = 8'h80;
        4'h9: seg_d = 8'h90;
        4'hA: seg_d = 8'h88;
        4'hB: seg_d = 8'h83;
        4'hC: seg_d = 8'hC6;
        4'hD: seg_d = 8'hA1;
        4'hE: seg_d = 8'h86;
        4'hF: seg_d = 8'h8E;
        default: seg_d = 8'hFF;
      endcase
    end
  end

  // seg and an are both derived from the same registered digit, so they switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q  <= '0;
      digit_q <= '0;
      seg_q   <= '1;
      an_q    <= '1;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_read = mem_read_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
